// File: rtl/mapa_cell_writer.sv
// Map RAM command front-end; optional shadow readback via MAPA_READBACK_EN. Cell write lands 1 cycle after
// accept, clear sweeps 64 cycles; CmdReady stays low (backpressure) whenever the block is outside IDLE.
module mapa_cell_writer #(
  parameter int MAP_W     = 8,
  parameter int MAP_CELLS = 64,
  parameter int MAX_CODE  = 6
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [1:0] CmdOp,
  input  logic [2:0] CmdX,
  input  logic [2:0] CmdY,
  input  logic [3:0] CmdCode,
  output logic       Busy,
  output logic       ErrSticky,
  input  logic       ErrClear,
  output logic [3:0] MapaData,
  output logic [5:0] MapaAddr,
  output logic       MapaWrite
`ifdef MAPA_READBACK_EN
  ,
  input  logic [2:0] RdX,
  input  logic [2:0] RdY,
  output logic [3:0] RdData
`endif
);

  localparam int ADDR_W = 6;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(MAP_CELLS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [3:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;

  logic              accept;
  logic              code_bad;
  logic [3:0]        code_safe;
  logic [ADDR_W-1:0] cell_addr;
  logic              err_set;

  assign accept    = CmdValid & ready_q;
  assign code_bad  = CmdCode > 4'(MAX_CODE);
  assign code_safe = code_bad ? 4'd0 : CmdCode;
  assign cell_addr = ADDR_W'(CmdX) + ADDR_W'(CmdY) * ADDR_W'(MAP_W);

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    data_d  = data_q;
    addr_d  = addr_q;
    write_d = 1'b0;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          case (CmdOp)
            2'b00: begin
              state_d = WRITE;
              ready_d = 1'b0;
              write_d = 1'b1;
              addr_d  = cell_addr;
              data_d  = code_safe;
              err_set = code_bad;
            end
            2'b01: begin
              // Fill code parks in the data register for the whole sweep.
              state_d = CLEAR;
              ready_d = 1'b0;
              busy_d  = 1'b1;
              write_d = 1'b1;
              addr_d  = '0;
              sweep_d = '0;
              data_d  = code_safe;
              err_set = code_bad;
            end
            2'b11:   err_set = 1'b1;
            default: ;
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      CLEAR: begin
        if (sweep_q == LAST_CELL) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          sweep_d = sweep_q + 1'b1;
          addr_d  = sweep_q + 1'b1;
          write_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
    err_d = ErrClear ? 1'b0 : (err_q | err_set);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      write_q <= write_d;
    end
  end

  assign CmdReady  = ready_q;
  assign Busy      = busy_q;
  assign ErrSticky = err_q;
  assign MapaData  = data_q;
  assign MapaAddr  = addr_q;
  assign MapaWrite = write_q;

`ifdef MAPA_READBACK_EN
  logic [3:0]        shadow_q [MAP_CELLS];
  logic [3:0]        shadow_d [MAP_CELLS];
  logic [3:0]        rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] rd_addr;

  assign rd_addr = ADDR_W'(RdX) + ADDR_W'(RdY) * ADDR_W'(MAP_W);

  // Read uses the pre-edge shadow, so a same-cycle write returns the old value.
  always_comb begin
    shadow_d = shadow_q;
    if (write_q) shadow_d[addr_q] = data_q;
    rd_data_d = shadow_q[rd_addr];
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < MAP_CELLS; i++) shadow_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign RdData = rd_data_q;
`endif

endmodule

// File: tb/tb_mapa_cell_writer.sv
// Directed bench for mapa_cell_writer: inputs driven and outputs sampled on the falling edge.
module tb_mapa_cell_writer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic       CmdReady;
  logic [1:0] CmdOp;
  logic [2:0] CmdX;
  logic [2:0] CmdY;
  logic [3:0] CmdCode;
  logic       Busy;
  logic       ErrSticky;
  logic       ErrClear;
  logic [3:0] MapaData;
  logic [5:0] MapaAddr;
  logic       MapaWrite;
`ifdef MAPA_READBACK_EN
  logic [2:0] RdX;
  logic [2:0] RdY;
  logic [3:0] RdData;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 Clock = ~Clock;

  mapa_cell_writer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .CmdValid  (CmdValid),
    .CmdReady  (CmdReady),
    .CmdOp     (CmdOp),
    .CmdX      (CmdX),
    .CmdY      (CmdY),
    .CmdCode   (CmdCode),
    .Busy      (Busy),
    .ErrSticky (ErrSticky),
    .ErrClear  (ErrClear),
    .MapaData  (MapaData),
    .MapaAddr  (MapaAddr),
    .MapaWrite (MapaWrite)
`ifdef MAPA_READBACK_EN
    ,
    .RdX       (RdX),
    .RdY       (RdY),
    .RdData    (RdData)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present a command for one edge (caller ensures CmdReady=1), then scramble operands.
  task automatic send(input logic [1:0] op, input logic [2:0] x, input logic [2:0] y, input logic [3:0] code);
    CmdOp = op; CmdX = x; CmdY = y; CmdCode = code; CmdValid = 1'b1;
    @(negedge Clock);
    CmdValid = 1'b0;
    CmdOp = 2'b00; CmdX = 3'd5; CmdY = 3'd6; CmdCode = 4'd1;
  endtask

  // Packed view: {MapaWrite, Busy, CmdReady, ErrSticky, MapaAddr, MapaData}
  function automatic logic [31:0] st();
    return {18'd0, MapaWrite, Busy, CmdReady, ErrSticky, MapaAddr, MapaData};
  endfunction

  function automatic logic [31:0] ex(input logic w, input logic b, input logic r, input logic e,
                                     input logic [5:0] a, input logic [3:0] d);
    return {18'd0, w, b, r, e, a, d};
  endfunction

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; CmdOp = 2'b10; CmdX = '0; CmdY = '0; CmdCode = '0; ErrClear = 1'b0;
`ifdef MAPA_READBACK_EN
    RdX = '0; RdY = '0;
`endif
    repeat (2) @(negedge Clock);
    chk("reset_state", st(), ex(0, 0, 0, 0, 6'd0, 4'd0));
    Reset = 1'b0;
    @(negedge Clock);
    chk("ready_after_reset", st(), ex(0, 0, 1, 0, 6'd0, 4'd0));

    // Single write x=3 y=2 code=5
    send(2'b00, 3'd3, 3'd2, 4'd5);
    chk("write1_pulse", st(), ex(1, 0, 0, 0, 6'd19, 4'd5));
    @(negedge Clock);
    chk("write1_done", st(), ex(0, 0, 1, 0, 6'd19, 4'd5));

    // Clear with fill 4
    send(2'b01, 3'd0, 3'd0, 4'd4);
    for (int i = 0; i < 64; i++) begin
      chk($sformatf("clear_cyc%0d", i), st(), ex(1, 1, 0, 0, 6'(i), 4'd4));
      @(negedge Clock);
    end
    chk("clear_done", st(), ex(0, 0, 1, 0, 6'd63, 4'd4));

    // Illegal code: written as 0, error set
    send(2'b00, 3'd7, 3'd7, 4'd9);
    chk("badcode_pulse", st(), ex(1, 0, 0, 1, 6'd63, 4'd0));
    @(negedge Clock);
    ErrClear = 1'b1;
    @(negedge Clock);
    ErrClear = 1'b0;
    chk("errclear", st(), ex(0, 0, 1, 0, 6'd63, 4'd0));

    // ErrClear beats a same-cycle reserved-op error
    ErrClear = 1'b1;
    send(2'b11, 3'd0, 3'd0, 4'd0);
    ErrClear = 1'b0;
    chk("clear_wins", st(), ex(0, 0, 1, 0, 6'd63, 4'd0));

    // Reserved op then nop: no writes, error latched
    send(2'b11, 3'd1, 3'd1, 4'd1);
    chk("op11_err", st(), ex(0, 0, 1, 1, 6'd63, 4'd0));
    send(2'b10, 3'd2, 3'd2, 4'd2);
    chk("op10_nowrite", st(), ex(0, 0, 1, 1, 6'd63, 4'd0));
    ErrClear = 1'b1;
    @(negedge Clock);
    ErrClear = 1'b0;
    chk("errclear2", st(), ex(0, 0, 1, 0, 6'd63, 4'd0));

    // CmdValid held: same write every 2 cycles
    CmdOp = 2'b00; CmdX = 3'd0; CmdY = 3'd1; CmdCode = 4'd3; CmdValid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      chk($sformatf("held_pulse%0d", k), st(), ex(1, 0, 0, 0, 6'd8, 4'd3));
      @(negedge Clock);
      chk($sformatf("held_gap%0d", k), st(), ex(0, 0, 1, 0, 6'd8, 4'd3));
    end
    CmdValid = 1'b0;

    // Reset in the middle of a clear sweep
    send(2'b01, 3'd0, 3'd0, 4'd2);
    repeat (19) @(negedge Clock);
    chk("sweep_cyc20", st(), ex(1, 1, 0, 0, 6'd19, 4'd2));
    Reset = 1'b1;
    #1;
    chk("reset_midsweep", st(), ex(0, 0, 0, 0, 6'd0, 4'd0));
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    chk("ready_after_reset2", st(), ex(0, 0, 1, 0, 6'd0, 4'd0));
    send(2'b00, 3'd3, 3'd2, 4'd5);
    chk("write2_pulse", st(), ex(1, 0, 0, 0, 6'd19, 4'd5));
    @(negedge Clock);
    chk("write2_done", st(), ex(0, 0, 1, 0, 6'd19, 4'd5));

`ifdef MAPA_READBACK_EN
    send(2'b00, 3'd1, 3'd1, 4'd2);
    @(negedge Clock);
    RdX = 3'd1; RdY = 3'd1;
    @(negedge Clock);
    chk("rd_written", {28'd0, RdData}, 32'd2);
    RdX = 3'd0; RdY = 3'd0;
    @(negedge Clock);
    chk("rd_unwritten", {28'd0, RdData}, 32'd0);
    RdX = 3'd3; RdY = 3'd2;
    @(negedge Clock);
    chk("rd_cell19", {28'd0, RdData}, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
